// File: rtl/dram_device_responder.sv
// dram_device_responder: cycle-level DRAM device decoding ACT/PRE/READ/WRITE with tRP, tRCD and CAS-latency timing
module dram_device_responder #(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 10,
  parameter int TRP      = 5,
  parameter int TRCD     = 5,
  parameter int CL       = 5
) (
  input  logic        CK,
  input  logic        RST,
  input  logic        CSn,
  input  logic        RASn,
  input  logic        CASn,
  input  logic [3:0]  WEn,
  input  logic [10:0] A,
  input  logic [31:0] D,
  output logic [31:0] Q,
  output logic        valid,
  output logic        row_open,
  output logic        cmd_err
);
  typedef enum logic [1:0] {CLOSED, PRECHARGING, ACTIVATING, ACTIVE} state_t;
  localparam int TMAX = TRP > TRCD ? TRP : TRCD;
  localparam int TW = $clog2(TMAX + 1);
  localparam int CW = $clog2(CL + 1);
  state_t state;
  logic [TW-1:0] tmr;
  logic [CW-1:0] rd_cnt;
  logic rd_busy;
  logic [31:0] rd_data;
  logic [ROW_BITS-1:0] open_row;
  logic [31:0] mem [0:(1 << (ROW_BITS + COL_BITS)) - 1];
  logic [ROW_BITS+COL_BITS-1:0] addr;
  logic is_nop, is_act, is_pre, is_rd, is_wr;
  logic acc_act, acc_pre, acc_rd, acc_wr, bad_cmd;
  always_comb begin
    addr    = {open_row, A[COL_BITS-1:0]};
    is_nop  = CSn || (RASn && CASn);
    is_act  = !CSn && !RASn && CASn && WEn == 4'hF;
    is_pre  = !CSn && !RASn && CASn && WEn == 4'h0;
    is_rd   = !CSn && RASn && !CASn && WEn == 4'hF;
    is_wr   = !CSn && RASn && !CASn && WEn != 4'hF;
    acc_act = is_act && state == CLOSED;
    acc_pre = is_pre && (state == CLOSED || state == ACTIVE);
    acc_rd  = is_rd && state == ACTIVE && !rd_busy;
    acc_wr  = is_wr && state == ACTIVE;
    bad_cmd = !is_nop && !(acc_act || acc_pre || acc_rd || acc_wr);
  end
  always_ff @(posedge CK) begin
    if (RST) begin
      state    <= CLOSED;
      tmr      <= '0;
      rd_cnt   <= '0;
      rd_busy  <= 1'b0;
      rd_data  <= '0;
      open_row <= '0;
      Q        <= '0;
      valid    <= 1'b0;
      row_open <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      valid    <= 1'b0;
      row_open <= state == ACTIVATING || state == ACTIVE;
      if (bad_cmd) cmd_err <= 1'b1;
      if (acc_act) begin
        state    <= TRCD > 1 ? ACTIVATING : ACTIVE;
        tmr      <= TW'(1);
        open_row <= A[ROW_BITS-1:0];
      end else if (acc_pre && state == ACTIVE) begin
        state <= TRP > 1 ? PRECHARGING : CLOSED;
        tmr   <= TW'(1);
      end else if (state == PRECHARGING && tmr == TW'(TRP - 1))
        state <= CLOSED;
      else if (state == ACTIVATING && tmr == TW'(TRCD - 1))
        state <= ACTIVE;
      else if (state == PRECHARGING || state == ACTIVATING)
        tmr <= tmr + 1'b1;
      // The word is snapshotted at the READ edge so later writes cannot disturb it
      if (acc_rd) begin
        rd_busy <= 1'b1;
        rd_cnt  <= CW'(1);
        rd_data <= mem[addr];
      end else if (rd_busy) begin
        if (rd_cnt == CW'(CL)) begin
          rd_busy <= 1'b0;
          valid   <= 1'b1;
          Q       <= rd_data;
        end else
          rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end
  always_ff @(posedge CK)
    if (acc_wr && !RST)
      for (int i = 0; i < 4; i++)
        if (!WEn[i]) mem[addr][8*i +: 8] <= D[8*i +: 8];
endmodule
